light_pen_locator: RTL and testbench

LIGHT_PEN_LOCATOR -- requirements
Module: light_pen_locator

---
 rtl/light_pen_locator_if.sv | 34 +++
 rtl/light_pen_locator.sv | 173 +++++++++++++++++
 tb/tb_light_pen_locator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/light_pen_locator_if.sv
// Pixel-scan inputs and pen-position outputs of the light-pen locator.
// The hit_cnt signal exists only when LPEN_HIT_COUNT_EN is defined.
interface light_pen_locator_if;
    logic       pen_in;
    logic [5:0] pixel_idx;
    logic       pixel_on;
    logic       frame_start;
    logic [2:0] row_d;
    logic [2:0] col_d;
    logic       pos_valid;
    logic       hit_pulse;
    logic       frame_hit;
`ifdef LPEN_HIT_COUNT_EN
    logic [7:0] hit_cnt;

    modport master (
        output pen_in, pixel_idx, pixel_on, frame_start,
        input  row_d, col_d, pos_valid, hit_pulse, frame_hit, hit_cnt
    );
    modport slave (
        input  pen_in, pixel_idx, pixel_on, frame_start,
        output row_d, col_d, pos_valid, hit_pulse, frame_hit, hit_cnt
    );
`else
    modport master (
        output pen_in, pixel_idx, pixel_on, frame_start,
        input  row_d, col_d, pos_valid, hit_pulse, frame_hit
    );
    modport slave (
        input  pen_in, pixel_idx, pixel_on, frame_start,
        output row_d, col_d, pos_valid, hit_pulse, frame_hit
    );
`endif
endinterface

// File: rtl/light_pen_locator.sv
// Locks onto the 8x8 matrix pixel seen by a light pen; LPEN_HIT_COUNT_EN adds the hit_cnt counter.
// Latency: pen_in reaches the hit logic after 2 sync flops; position outputs update the cycle after frame_start.
// Backpressure: none, every input is sampled on each clock.
module light_pen_locator #(
    parameter int SETTLE_CYC     = 16,
    parameter int CONFIRM_FRAMES = 2,
    parameter int MISS_FRAMES    = 3
) (
    input  logic               clk,
    input  logic               rst,
    light_pen_locator_if.slave bus
);
    localparam logic [7:0] SETTLE_N  = 8'(SETTLE_CYC);
    localparam logic [2:0] CONFIRM_N = 3'(CONFIRM_FRAMES);
    localparam logic [2:0] MISS_N    = 3'(MISS_FRAMES);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    logic       pen_meta, pen_s;
    logic       pixel_on_q;
    logic [7:0] dwell;
    logic       armed, frm_hit;
    logic [5:0] frm_pix;
    logic       pix_rise, hit_now, frame_eval;

    state_t     state, state_nx;
    logic [5:0] cand, cand_nx;
    logic [2:0] conf_cnt, conf_nx;
    logic [2:0] miss_cnt, miss_nx;
    logic [2:0] row_q, row_nx, col_q, col_nx;
    logic       pv_q, pv_nx, hp_q, hp_nx, fh_q;

    assign pix_rise   = bus.pixel_on & ~pixel_on_q;
    // The register still holds the previous pixel's saturated count on the rising cycle.
    assign hit_now    = bus.pixel_on & ~pix_rise & ~bus.frame_start & pen_s & (dwell == SETTLE_N);
    assign frame_eval = bus.frame_start & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pen_meta   <= 1'b0;
            pen_s      <= 1'b0;
            pixel_on_q <= 1'b0;
            dwell      <= '0;
        end else begin
            pen_meta   <= bus.pen_in;
            pen_s      <= pen_meta;
            pixel_on_q <= bus.pixel_on;
            if (pix_rise)
                dwell <= '0;
            else if (bus.pixel_on && dwell != SETTLE_N)
                dwell <= dwell + 8'd1;
        end
    end

    // Only the first hit of a frame becomes its candidate; the first frame_start after reset just arms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            frm_hit <= 1'b0;
            frm_pix <= '0;
            fh_q    <= 1'b0;
        end else if (bus.frame_start) begin
            armed   <= 1'b1;
            frm_hit <= 1'b0;
            fh_q    <= armed & frm_hit;
        end else if (hit_now && !frm_hit) begin
            frm_hit <= 1'b1;
            frm_pix <= bus.pixel_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            cand     <= '0;
            conf_cnt <= '0;
            miss_cnt <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pv_q     <= 1'b0;
            hp_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            conf_cnt <= conf_nx;
            miss_cnt <= miss_nx;
            row_q    <= row_nx;
            col_q    <= col_nx;
            pv_q     <= pv_nx;
            hp_q     <= hp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        conf_nx  = conf_cnt;
        miss_nx  = miss_cnt;
        row_nx   = row_q;
        col_nx   = col_q;
        pv_nx    = pv_q;
        hp_nx    = 1'b0;
        if (frame_eval) begin
            if (!frm_hit) begin
                // A blank frame only counts as a miss while a position is being reported.
                if (pv_q) begin
                    if (miss_cnt + 3'd1 >= MISS_N) begin
                        state_nx = SEARCH;
                        pv_nx    = 1'b0;
                        miss_nx  = '0;
                        conf_nx  = '0;
                    end else begin
                        miss_nx = miss_cnt + 3'd1;
                    end
                end else begin
                    state_nx = SEARCH;
                    conf_nx  = '0;
                end
            end else begin
                miss_nx = '0;
                case (state)
                    LOCKED: begin
                        if (frm_pix != {row_q, col_q}) begin
                            state_nx = CONFIRM;
                            cand_nx  = frm_pix;
                            conf_nx  = 3'd1;
                        end
                    end
                    CONFIRM: begin
                        if (frm_pix == cand) begin
                            conf_nx = conf_cnt + 3'd1;
                        end else begin
                            cand_nx = frm_pix;
                            conf_nx = 3'd1;
                        end
                    end
                    default: begin
                        state_nx = CONFIRM;
                        cand_nx  = frm_pix;
                        conf_nx  = 3'd1;
                    end
                endcase
                if (state_nx == CONFIRM && conf_nx >= CONFIRM_N) begin
                    state_nx         = LOCKED;
                    {row_nx, col_nx} = cand_nx;
                    pv_nx            = 1'b1;
                    hp_nx            = 1'b1;
                end
            end
        end
    end

    assign bus.row_d     = row_q;
    assign bus.col_d     = col_q;
    assign bus.pos_valid = pv_q;
    assign bus.hit_pulse = hp_q;
    assign bus.frame_hit = fh_q;

`ifdef LPEN_HIT_COUNT_EN
    logic [7:0] hit_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hit_cnt_q <= '0;
        else if (hp_q)
            hit_cnt_q <= hit_cnt_q + 8'd1;
    end

    assign bus.hit_cnt = hit_cnt_q;
`else
    // Build without the lock-event counter.
`endif
endmodule

// File: tb/tb_light_pen_locator.sv
// Bench for light_pen_locator: directed frame scenarios plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_light_pen_locator;
    localparam int SETTLE = 16;
    localparam int CONF   = 2;
    localparam int MISS   = 3;
    localparam int DWELL  = 20;
    localparam int S_SEARCH = 0, S_CONFIRM = 1, S_LOCKED = 2;

    logic clk = 1'b0;
    logic rst;
    light_pen_locator_if bus();

    light_pen_locator #(
        .SETTLE_CYC(SETTLE), .CONFIRM_FRAMES(CONF), .MISS_FRAMES(MISS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   hp_seen = 0;
    logic obs_pv, obs_hp, obs_fh;
    logic [2:0] obs_row, obs_col;

    // Frame-level reference: candidate pixel per frame, lock/miss bookkeeping per evaluation.
    int m_state, m_cand, m_cnt, m_miss, m_pos, m_pend;
    int m_locks_total = 0;
    int m_locks_rst = 0;
    bit m_pv, m_armed, e_hp, e_fh;

    always @(negedge clk) if (bus.hit_pulse === 1'b1) hp_seen++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] bit_of(input int i);
        logic [63:0] r;
        r = 64'd1 << i;
        return r;
    endfunction

    function automatic int frame_cand(input logic [63:0] mask, input int len);
        if (len < SETTLE) return -1;
        for (int i = 0; i < 64; i++) if (mask[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = S_SEARCH; m_cand = 0; m_cnt = 0; m_miss = 0; m_pos = 0;
        m_pend = -1; m_pv = 0; m_armed = 0; e_hp = 0; e_fh = 0; m_locks_rst = 0;
    endtask

    task automatic model_start(input int c);
        e_hp = 0;
        if (!m_armed) begin
            m_armed = 1;
            e_fh = 0;
        end else begin
            e_fh = (m_pend >= 0);
            if (m_pend < 0) begin
                if (m_pv) begin
                    m_miss++;
                    if (m_miss >= MISS) begin m_pv = 0; m_state = S_SEARCH; m_miss = 0; end
                end else begin
                    m_state = S_SEARCH;
                end
            end else if (m_state == S_LOCKED && m_pend == m_pos) begin
                m_miss = 0;
            end else begin
                m_miss = 0;
                if (m_state == S_CONFIRM && m_pend == m_cand) m_cnt++;
                else begin m_cand = m_pend; m_cnt = 1; m_state = S_CONFIRM; end
                if (m_cnt >= CONF) begin
                    m_state = S_LOCKED; m_pos = m_cand; m_pv = 1; e_hp = 1;
                    m_locks_total++; m_locks_rst++;
                end
            end
        end
        m_pend = c;
    endtask

    task automatic capture();
        obs_pv = bus.pos_valid; obs_hp = bus.hit_pulse; obs_fh = bus.frame_hit;
        obs_row = bus.row_d; obs_col = bus.col_d;
    endtask

    task automatic drive_pixel(input int idx, input logic pen, input int len, input bit fs);
        for (int c = 0; c < DWELL; c++) begin
            @(negedge clk);
            if (c == 1 && fs) capture();
            bus.pixel_on = 1'b1;
            bus.pixel_idx = 6'(idx);
            bus.frame_start = (c == 0) && fs;
            bus.pen_in = pen && (c < len);
        end
        @(negedge clk);
        bus.pixel_on = 1'b0; bus.pen_in = 1'b0; bus.frame_start = 1'b0;
    endtask

    task automatic run_frame(input logic [63:0] mask, input int len, input bit fs_alone);
        model_start(frame_cand(mask, len));
        if (fs_alone) begin
            @(negedge clk);
            bus.frame_start = 1'b1; bus.pixel_on = 1'b0; bus.pen_in = 1'b0;
            @(negedge clk);
            capture();
            bus.frame_start = 1'b0;
        end
        for (int i = 0; i < 64; i++) drive_pixel(i, mask[i], len, (i == 0) && !fs_alone);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pen_in = 1'b0; bus.pixel_idx = '0; bus.pixel_on = 1'b0; bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got=%b exp=0", bus.pos_valid); end
        checks++; if (bus.row_d !== 3'd0) begin errors++; $display("FAIL reset_row got=%0d exp=0", bus.row_d); end
        checks++; if (bus.col_d !== 3'd0) begin errors++; $display("FAIL reset_col got=%0d exp=0", bus.col_d); end
        checks++; if (bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL reset_hp got=%b exp=0", bus.hit_pulse); end
        checks++; if (bus.frame_hit !== 1'b0) begin errors++; $display("FAIL reset_fh got=%b exp=0", bus.frame_hit); end
`ifdef LPEN_HIT_COUNT_EN
        checks++; if (bus.hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.hit_cnt); end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_short_pulse();
        run_frame(bit_of(27), 10, 0);
        checks++; if (obs_pv !== 1'b0 || obs_fh !== 1'b0) begin errors++; $display("FAIL arm_frame got pv=%b fh=%b exp 0/0", obs_pv, obs_fh); end
        run_frame(bit_of(27), 10, 0);
        checks++; if (obs_fh !== 1'b0) begin errors++; $display("FAIL short_fh1 got=%b exp=0", obs_fh); end
    endtask

    task automatic test_lock();
        run_frame(bit_of(27), 20, 0);
        checks++; if (obs_fh !== 1'b0 || obs_pv !== 1'b0) begin errors++; $display("FAIL short_fh2 got fh=%b pv=%b exp 0/0", obs_fh, obs_pv); end
        run_frame(bit_of(27), 20, 0);
        checks++; if (obs_fh !== 1'b1) begin errors++; $display("FAIL lock_fh got=%b exp=1", obs_fh); end
        checks++; if (obs_pv !== 1'b0 || obs_hp !== 1'b0) begin errors++; $display("FAIL lock_early got pv=%b hp=%b exp 0/0", obs_pv, obs_hp); end
        run_frame('0, 20, 0);
        checks++; if (obs_hp !== 1'b1) begin errors++; $display("FAIL lock_hp got=%b exp=1", obs_hp); end
        checks++; if (obs_pv !== 1'b1) begin errors++; $display("FAIL lock_pv got=%b exp=1", obs_pv); end
        checks++; if (obs_row !== 3'd3 || obs_col !== 3'd3) begin errors++; $display("FAIL lock_pos got=%0d/%0d exp=3/3", obs_row, obs_col); end
    endtask

    task automatic test_loss();
        run_frame('0, 20, 0);
        checks++; if (obs_pv !== 1'b1 || obs_hp !== 1'b0) begin errors++; $display("FAIL miss1 got pv=%b hp=%b exp 1/0", obs_pv, obs_hp); end
        run_frame('0, 20, 0);
        checks++; if (obs_pv !== 1'b1) begin errors++; $display("FAIL miss2 got pv=%b exp=1", obs_pv); end
        run_frame(bit_of(27), 20, 0);
        checks++; if (obs_pv !== 1'b0) begin errors++; $display("FAIL miss3_pv got=%b exp=0", obs_pv); end
        checks++; if (obs_row !== 3'd3 || obs_col !== 3'd3) begin errors++; $display("FAIL miss3_hold got=%0d/%0d exp=3/3", obs_row, obs_col); end
    endtask

    task automatic test_move();
        run_frame(bit_of(27), 20, 0);
        checks++; if (obs_pv !== 1'b0 || obs_fh !== 1'b1) begin errors++; $display("FAIL relock1 got pv=%b fh=%b exp 0/1", obs_pv, obs_fh); end
        run_frame(bit_of(28), 20, 0);
        checks++; if (obs_hp !== 1'b1 || obs_pv !== 1'b1) begin errors++; $display("FAIL relock2 got hp=%b pv=%b exp 1/1", obs_hp, obs_pv); end
        run_frame(bit_of(28), 20, 0);
        checks++; if (obs_pv !== 1'b1 || obs_hp !== 1'b0) begin errors++; $display("FAIL move1 got pv=%b hp=%b exp 1/0", obs_pv, obs_hp); end
        checks++; if (obs_row !== 3'd3 || obs_col !== 3'd3) begin errors++; $display("FAIL move1_pos got=%0d/%0d exp=3/3", obs_row, obs_col); end
        run_frame('0, 20, 1);
        checks++; if (obs_pv !== 1'b1 || obs_hp !== 1'b1) begin errors++; $display("FAIL move2 got pv=%b hp=%b exp 1/1", obs_pv, obs_hp); end
        checks++; if (obs_row !== 3'd3 || obs_col !== 3'd4) begin errors++; $display("FAIL move2_pos got=%0d/%0d exp=3/4", obs_row, obs_col); end
    endtask

    task automatic test_two_hits();
        run_frame(bit_of(5) | bit_of(40), 20, 0);
        checks++; if (obs_pv !== 1'b1 || obs_fh !== 1'b0) begin errors++; $display("FAIL two_a got pv=%b fh=%b exp 1/0", obs_pv, obs_fh); end
        run_frame(bit_of(5) | bit_of(40), 20, 0);
        checks++; if (obs_fh !== 1'b1 || obs_hp !== 1'b0) begin errors++; $display("FAIL two_b got fh=%b hp=%b exp 1/0", obs_fh, obs_hp); end
        run_frame('0, 20, 0);
        checks++; if (obs_hp !== 1'b1) begin errors++; $display("FAIL two_hp got=%b exp=1", obs_hp); end
        checks++; if (obs_row !== 3'd0 || obs_col !== 3'd5) begin errors++; $display("FAIL two_pos got=%0d/%0d exp=0/5", obs_row, obs_col); end
    endtask

    task automatic test_reset_mid();
        model_start(frame_cand(bit_of(5), 20));
        for (int i = 0; i < 32; i++) drive_pixel(i, i == 5, 20, i == 0);
        checks++; if (obs_pv !== 1'b1 || obs_row !== 3'd0 || obs_col !== 3'd5) begin
            errors++; $display("FAIL pre_rst got pv=%b pos=%0d/%0d exp 1 0/5", obs_pv, obs_row, obs_col); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.pos_valid !== 1'b0 || bus.row_d !== 3'd0 || bus.col_d !== 3'd0) begin
            errors++; $display("FAIL rst_async got pv=%b pos=%0d/%0d exp 0 0/0", bus.pos_valid, bus.row_d, bus.col_d); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 32; i < 64; i++) drive_pixel(i, i == 40, 20, 0);
        run_frame(bit_of(40), 20, 0);
        checks++; if (obs_pv !== 1'b0 || obs_fh !== 1'b0) begin errors++; $display("FAIL rst_arm got pv=%b fh=%b exp 0/0", obs_pv, obs_fh); end
        run_frame(bit_of(40), 20, 0);
        checks++; if (obs_pv !== 1'b0 || obs_hp !== 1'b0) begin errors++; $display("FAIL rst_disc got pv=%b hp=%b exp 0/0", obs_pv, obs_hp); end
        run_frame('0, 20, 0);
        checks++; if (obs_hp !== 1'b1 || obs_pv !== 1'b1 || obs_row !== 3'd5 || obs_col !== 3'd0) begin
            errors++; $display("FAIL rst_relock got hp=%b pv=%b pos=%0d/%0d exp 1 1 5/0", obs_hp, obs_pv, obs_row, obs_col); end
    endtask

    task automatic test_random();
        int fav, k, len, f;
        logic [63:0] mask;
        fav = int'($urandom_range(0, 63));
        for (f = 0; f <= 16; f++) begin
            mask = '0;
            len = 20;
            k = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) fav = int'($urandom_range(0, 63));
            if (f == 16) mask = '0;
            else if (k <= 1) mask = '0;
            else if (k <= 5) mask = bit_of(fav);
            else if (k <= 7) mask = bit_of(int'($urandom_range(0, 63)));
            else if (k == 8) mask = bit_of(fav) | bit_of(int'($urandom_range(0, 63)));
            else begin mask = bit_of(fav); len = 10; end
            run_frame(mask, len, $urandom_range(0, 3) == 0);
            checks++; if (obs_pv !== m_pv) begin errors++; $display("FAIL rnd%0d_pv got=%b exp=%b", f, obs_pv, m_pv); end
            checks++; if (obs_hp !== e_hp) begin errors++; $display("FAIL rnd%0d_hp got=%b exp=%b", f, obs_hp, e_hp); end
            checks++; if (obs_fh !== e_fh) begin errors++; $display("FAIL rnd%0d_fh got=%b exp=%b", f, obs_fh, e_fh); end
            checks++; if (obs_row !== 3'(m_pos / 8) || obs_col !== 3'(m_pos % 8)) begin
                errors++; $display("FAIL rnd%0d_pos got=%0d/%0d exp=%0d/%0d", f, obs_row, obs_col, m_pos / 8, m_pos % 8); end
        end
        repeat (3) @(negedge clk);
        checks++; if (hp_seen != m_locks_total) begin errors++; $display("FAIL hp_total got=%0d exp=%0d", hp_seen, m_locks_total); end
`ifdef LPEN_HIT_COUNT_EN
        checks++; if (bus.hit_cnt !== 8'(m_locks_rst)) begin errors++; $display("FAIL hit_cnt got=%0d exp=%0d", bus.hit_cnt, m_locks_rst); end
`endif
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_lock();
        test_loss();
        test_move();
        test_two_hits();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
